// File: rtl/nreg_write_arbiter.sv
// Round-robin write arbiter in front of a single shared WIDTH-bit register.
// A granted requester may lock ownership for back-to-back writes, bounded by MAX_LOCK cycles.
module nreg_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 8,
    localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(MAX_LOCK)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         io_req_valid,
    input  logic [NREQ*WIDTH-1:0]   io_req_data,
    input  logic [NREQ-1:0]         io_req_lock,
    output logic [NREQ-1:0]         io_req_ready,
    output logic [WIDTH-1:0]        io_Q,
    output logic [PW-1:0]           io_owner,
    output logic                    io_update,
    output logic                    io_lock_active,
    output logic                    io_lock_timeout
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      w_rr_next;
    logic [PW-1:0]      r_lock_owner;
    logic [PW-1:0]      w_lock_owner_next;
    logic [CW-1:0]      r_lock_cnt;
    logic [CW-1:0]      w_lock_cnt_next;
    logic [WIDTH-1:0]   r_q;
    logic [PW-1:0]      r_owner;
    logic               r_update;
    logic               r_timeout;
    logic               w_timeout_next;

    logic [NREQ-1:0]    w_ready;
    logic [PW-1:0]      w_win;
    logic               w_win_found;
    logic [PW-1:0]      w_scan;
    logic [PW-1:0]      w_grant;
    logic               w_write;
    logic [WIDTH-1:0]   w_data [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_data
            assign w_data[gi] = io_req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Wrap by compare so non-power-of-two NREQ never reaches an unused index.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        if (p == PW'(NREQ - 1))
            return '0;
        else
            return p + PW'(1);
    endfunction

    always_comb begin
        w_win       = r_rr_ptr;
        w_win_found = 1'b0;
        w_scan      = r_rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_win_found && io_req_valid[w_scan]) begin
                w_win       = w_scan;
                w_win_found = 1'b1;
            end
            w_scan = f_inc(w_scan);
        end
    end

    always_comb begin
        w_ready = '0;
        w_grant = r_lock_owner;
        if (r_state == S_IDLE) begin
            w_grant = w_win;
            if (w_win_found)
                w_ready[w_win] = 1'b1;
        end else begin
            w_ready[r_lock_owner] = io_req_valid[r_lock_owner];
        end
    end

    assign w_write = |w_ready;

    always_comb begin
        w_state_next      = r_state;
        w_rr_next         = r_rr_ptr;
        w_lock_owner_next = r_lock_owner;
        w_lock_cnt_next   = r_lock_cnt;
        w_timeout_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_write) begin
                    if (io_req_lock[w_win]) begin
                        w_state_next      = S_LOCKED;
                        w_lock_owner_next = w_win;
                        w_lock_cnt_next   = '0;
                    end else begin
                        w_rr_next = f_inc(w_win);
                    end
                end
            end
            S_LOCKED: begin
                w_lock_cnt_next = r_lock_cnt + CW'(1);
                // Forced release takes priority so the timeout pulse is never lost.
                if (r_lock_cnt == CW'(MAX_LOCK - 1)) begin
                    w_state_next    = S_IDLE;
                    w_rr_next       = f_inc(r_lock_owner);
                    w_lock_cnt_next = '0;
                    w_timeout_next  = 1'b1;
                end else if (!io_req_lock[r_lock_owner]) begin
                    w_state_next    = S_IDLE;
                    w_rr_next       = f_inc(r_lock_owner);
                    w_lock_cnt_next = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_lock_owner <= '0;
            r_lock_cnt   <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_rr_ptr     <= w_rr_next;
            r_lock_owner <= w_lock_owner_next;
            r_lock_cnt   <= w_lock_cnt_next;
            r_timeout    <= w_timeout_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q      <= '0;
            r_owner  <= '0;
            r_update <= 1'b0;
        end else begin
            r_update <= w_write;
            if (w_write) begin
                r_q     <= w_data[w_grant];
                r_owner <= w_grant;
            end
        end
    end

    // Ready is gated by reset so a mid-lock reset drops grants immediately.
    assign io_req_ready    = reset ? '0 : w_ready;
    assign io_Q            = r_q;
    assign io_owner        = r_owner;
    assign io_update       = r_update;
    assign io_lock_active  = (r_state == S_LOCKED);
    assign io_lock_timeout = r_timeout;

endmodule

// File: tb/tb_nreg_write_arbiter.sv
// Directed bench for nreg_write_arbiter: a 4-requester instance for the main plan
// and a 3-requester instance for non-power-of-two wrap and mid-lock reset.
module tb_nreg_write_arbiter;

    logic        clk;
    logic        reset;

    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  lock;
    logic [3:0]  ready;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        update;
    logic        lock_active;
    logic        timeout;

    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  l3;
    logic [2:0]  ready3;
    logic [7:0]  q3;
    logic [1:0]  owner3;
    logic        update3;
    logic        lock_active3;
    logic        timeout3;

    int n_cmp = 0;
    int n_err = 0;

    nreg_write_arbiter #(.NREQ(4), .WIDTH(8), .MAX_LOCK(8)) u_dut4 (
        .clk             (clk),
        .reset           (reset),
        .io_req_valid    (valid),
        .io_req_data     (data),
        .io_req_lock     (lock),
        .io_req_ready    (ready),
        .io_Q            (q),
        .io_owner        (owner),
        .io_update       (update),
        .io_lock_active  (lock_active),
        .io_lock_timeout (timeout)
    );

    nreg_write_arbiter #(.NREQ(3), .WIDTH(8), .MAX_LOCK(8)) u_dut3 (
        .clk             (clk),
        .reset           (reset),
        .io_req_valid    (v3),
        .io_req_data     (d3),
        .io_req_lock     (l3),
        .io_req_ready    (ready3),
        .io_Q            (q3),
        .io_owner        (owner3),
        .io_update       (update3),
        .io_lock_active  (lock_active3),
        .io_lock_timeout (timeout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && |ready)
            $display("txn dut4 t=%0t ready=%b data=%h", $time, ready, data);
        if (!reset && |ready3)
            $display("txn dut3 t=%0t ready=%b data=%h", $time, ready3, d3);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        valid = '0; data = '0; lock = '0;
        v3 = '0; d3 = '0; l3 = '0;

        // Outputs held at reset values, ready gated even with valid requests.
        #2;
        valid = 4'b1111;
        #1;
        chk("rst_ready", ready, 4'b0000);
        chk("rst_q", q, 8'h00);
        chk("rst_owner", owner, 2'd0);
        chk("rst_update", update, 1'b0);
        chk("rst_lock_active", lock_active, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single write from requester 0.
        valid = 4'b0001;
        data[7:0] = 8'hA5;
        #1;
        chk("t1_ready", ready, 4'b0001);
        tick();
        chk("t1_q", q, 8'hA5);
        chk("t1_owner", owner, 2'd0);
        chk("t1_update", update, 1'b1);
        valid = '0;
        tick();
        chk("t1_update_drop", update, 1'b0);
        chk("t1_q_hold", q, 8'hA5);

        // Async reset pulse clears io_Q and rr_ptr.
        reset = 1'b1;
        #2;
        chk("rst2_q", q, 8'h00);
        reset = 1'b0;

        // Round-robin with all four requesters valid.
        valid = 4'b1111;
        data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), ready, 32'(4'b0001 << (k % 4)));
            tick();
            chk($sformatf("rr_q_%0d", k), q, 32'h10 + 32'(k % 4));
            chk($sformatf("rr_owner_%0d", k), owner, 32'(k % 4));
        end
        valid = '0;

        // Req 1 locks (rr_ptr=1), req 2 waits; voluntary release.
        valid = 4'b0110;
        lock = 4'b0010;
        data = {8'h00, 8'hEE, 8'h01, 8'h00};
        #1;
        chk("lk_ready0", ready, 4'b0010);
        tick();
        chk("lk_q0", q, 8'h01);
        chk("lk_active0", lock_active, 1'b1);
        for (int k = 2; k <= 3; k++) begin
            data[15:8] = 8'(k);
            #1;
            chk($sformatf("lk_ready_%0d", k), ready, 4'b0010);
            tick();
            chk($sformatf("lk_q_%0d", k), q, 32'(k));
        end
        valid = 4'b0100;
        lock = 4'b0000;
        #1;
        chk("lk_rel_ready", ready, 4'b0000);
        tick();
        chk("lk_rel_active", lock_active, 1'b0);
        chk("lk_rel_timeout", timeout, 1'b0);
        chk("lk_rel_update", update, 1'b0);
        #1;
        chk("lk_next_ready", ready, 4'b0100);
        tick();
        chk("lk_next_q", q, 8'hEE);
        chk("lk_next_owner", owner, 2'd2);
        valid = '0;

        // Req 0 holds lock past MAX_LOCK; req 3 waiting (rr_ptr=3 before lock).
        valid = 4'b0001;
        lock = 4'b0001;
        data = {8'h33, 8'h00, 8'h00, 8'h40};
        #1;
        chk("to_take_ready", ready, 4'b0001);
        tick();
        chk("to_take_q", q, 8'h40);
        chk("to_take_active", lock_active, 1'b1);
        valid = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            data[7:0] = 8'h50 + 8'(k);
            #1;
            chk($sformatf("to_ready_%0d", k), ready, 4'b0001);
            tick();
            chk($sformatf("to_q_%0d", k), q, 32'h50 + 32'(k));
            chk($sformatf("to_active_%0d", k), lock_active, 32'(k < 7));
            chk($sformatf("to_pulse_%0d", k), timeout, 32'(k == 7));
        end
        #1;
        chk("to_after_ready", ready, 4'b1000);
        tick();
        chk("to_after_q", q, 8'h33);
        chk("to_after_owner", owner, 2'd3);
        chk("to_after_pulse", timeout, 1'b0);
        #1;
        chk("to_back0_ready", ready, 4'b0001);
        valid = '0;
        lock = '0;
        tick();

        // Lock drop coinciding with the final allowed locked cycle (rr_ptr=0).
        valid = 4'b0001;
        lock = 4'b0001;
        data[7:0] = 8'h60;
        tick();
        for (int k = 0; k < 7; k++) begin
            data[7:0] = 8'h61 + 8'(k);
            tick();
        end
        chk("sim_active", lock_active, 1'b1);
        chk("sim_q_pre", q, 8'h67);
        lock = 4'b0000;
        data[7:0] = 8'h6F;
        #1;
        chk("sim_ready", ready, 4'b0001);
        tick();
        chk("sim_q", q, 8'h6F);
        chk("sim_update", update, 1'b1);
        chk("sim_pulse", timeout, 1'b1);
        chk("sim_active_drop", lock_active, 1'b0);
        valid = '0;
        tick();
        chk("sim_pulse_drop", timeout, 1'b0);

        // NREQ=3 wrap-around: grants 0,1,2,0,1.
        v3 = 3'b111;
        d3 = {8'h22, 8'h21, 8'h20};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("n3_ready_%0d", k), ready3, 32'(3'b001 << (k % 3)));
            tick();
            chk($sformatf("n3_q_%0d", k), q3, 32'h20 + 32'(k % 3));
            chk($sformatf("n3_owner_%0d", k), owner3, 32'(k % 3));
        end

        // rr_ptr=2 now; req 1 locks, then reset mid-lock.
        v3 = 3'b010;
        l3 = 3'b010;
        #1;
        chk("n3_lock_ready", ready3, 3'b010);
        tick();
        chk("n3_lock_active", lock_active3, 1'b1);
        chk("n3_lock_q", q3, 8'h21);
        reset = 1'b1;
        #1;
        chk("n3_rst_ready", ready3, 3'b000);
        chk("n3_rst_q", q3, 8'h00);
        chk("n3_rst_active", lock_active3, 1'b0);
        reset = 1'b0;
        l3 = 3'b000;
        v3 = 3'b110;
        #1;
        chk("n3_rst_rrptr", ready3, 3'b010);
        v3 = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
